qspi_bus_arbiter: RTL and testbench
===================================

# qspi_bus_arbiter

Shares the single quad-SPI pad group (SCLK, IO0–IO3, flash CE0, PSRAM CE1) between the flash read controller (port 0) and the PSRAM read/write controller (port 1). It grants exclusive bus ownership with a req/gnt handshake and round-robin priority. It enforces a deselect guard interval between owners and muxes the owner's pin drive onto the pads. It sits between the two memory controllers and the `uio_*` pad signals of the SoC top.

## Interface

Parameters:
- `GUARD`, default 2: idle cycles (both CE high, SCLK low, IO not driven) inserted after every release; legal range 1..15.
- `MAX_HOLD`, default 1024: grant-cycle limit while the other port is requesting; exceeding it sets the starvation flag.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` input 1 each: bus request from the flash port and the PSRAM port.
- `m0_gnt`, `m1_gnt` output 1 each: registered grant; at most one is high.
- `m0_sclk`, `m1_sclk` input 1 each: port SCLK drive.
- `m0_cs_n`, `m1_cs_n` input 1 each: port chip select.
- `m0_io_out`, `m1_io_out` input 4 each: port IO drive value.
- `m0_io_oe`, `m1_io_oe` input 4 each: port IO output enable.
- `pad_sclk` output 1: to the SCLK pad.
- `pad_ce0_n` output 1: flash CE.
- `pad_ce1_n` output 1: PSRAM CE.
- `pad_io_out` output 4: to the IO pads.
- `pad_io_oe` output 4: to the IO pads.
- `pad_io_in` input 4: IO pad inputs.
- `io_in` output 4: `pad_io_in` broadcast to both ports, unmuxed.
- `starve` output 1: sticky flag, set on a `MAX_HOLD` violation.
- `starve_clr` input 1: clears `starve`.

## Operation

State machine states: `IDLE`, `OWN0`, `OWN1`, `GUARD`.

- **IDLE**
  - Exactly one `req` high: grant that port.
  - Both high: grant the port that was not the last owner.
  - Last owner resets to port 1, so port 0 wins the first tie after reset.
  - No request: stay in IDLE.
- **OWNx**
  - `mx_gnt`=1.
  - Pads follow the owner combinationally:
    - `pad_sclk`=`mx_sclk`
    - `pad_io_out`/`pad_io_oe` = the owner's values
    - owner's CE pad = `mx_cs_n`; the other CE pad is forced 1.
  - Owner deasserts `req`: go to GUARD, record last owner = x, drop `gnt`.
- **GUARD**
  - Pads in parked state: `pad_sclk`=0, `pad_io_oe`=0, `pad_io_out`=0, both CE pads 1.
  - Counter loads `GUARD-1` on entry and decrements each cycle.
  - At 0: apply the IDLE grant rules in the same cycle, so GUARD can go directly to OWNx with no IDLE cycle.
- **Parked pads:** IDLE and GUARD both drive the parked pad state.
- **Non-owner inputs:** ignored entirely.
- **Starvation:**
  - Hold counter clears on entry to OWNx.
  - It increments each OWNx cycle in which the other port's `req` is high, saturating.
  - When it reaches `MAX_HOLD`, `starve` sets.
  - No preemption; the owner keeps the bus.
  - `starve_clr` clears the flag; if set and clear occur in the same cycle, set wins.
- **Grant ownership:** a port must not drop `req` mid-transaction. The arbiter does not inspect `cs_n` for release and forces the owner's CE pad high in GUARD regardless.

## Timing

- **Reset values:** state IDLE, both `gnt` 0, pads parked (`pad_sclk` 0, both CE 1, `pad_io_out`/`pad_io_oe` 0), `starve` 0, last owner 1.
- **Reset mid-grant:** pads park immediately (asynchronous); the interrupted transaction is lost.
- **Grant latency:** `req` high at edge t in IDLE gives `gnt` high after edge t+1. Pads switch to the owner in that same cycle.
- **Release:** `req` low sampled at edge t drops `gnt` and parks pads after edge t+1. GUARD then lasts exactly `GUARD` cycles.
- **Handover latency:** the minimum bus-idle gap between owners is `GUARD` cycles. The next `gnt` rises on the edge that ends the last GUARD cycle.
- **Re-request:** a port that releases and immediately re-requests while the other port is waiting loses the tie (round-robin).
- **Mux path:** owner pins to pads is purely combinational. Grant and state are registered.

## Test plan

- **Single request:** after reset, `m0_req`=1 at cycle 5 -> `m0_gnt`=1 from cycle 6. `pad_ce0_n` follows `m0_cs_n`, `pad_ce1_n`=1, `m1_sclk` toggling not visible.
- **Tie after reset:** both `req` high at cycle 3 -> `m0` granted first. `m0` drops `req` at cycle 20 -> `gnt` low at 21, pads parked cycles 21–22 (`GUARD`=2), `m1_gnt`=1 at 23.
- **Round-robin:** `m1` releases while `m0_req` and `m1_req` are both high -> `m0` granted next. Over 10 alternating contention rounds, grants strictly alternate.
- **Starvation:** `MAX_HOLD`=8, `m0` holds while `m1_req` is high -> `starve`=1 after the 8th contended cycle. `starve_clr` pulse -> 0. Simultaneous set+clear -> stays 1.
- **Reset mid-grant:** `rst_n` low while in OWN1 with `m1_cs_n`=0 -> `pad_ce1_n`=1, `m1_gnt`=0 without waiting for a clock. After release, `m0` wins the first tie.
- **IO loopback:** external value 4'hA on `pad_io_in` -> `io_in`=4'hA in all states. `pad_io_oe`=0 in IDLE/GUARD.

Source files
------------

// File: rtl/qspi_bus_arbiter_if.sv
// Quad-SPI sharing bundle: both controller ports, the pad group and the starvation flag.
// The slave modport is the arbiter; the master modport is the controller/pad side.
interface qspi_bus_arbiter_if;
   logic       m0_req;
   logic       m1_req;
   logic       m0_gnt;
   logic       m1_gnt;
   logic       m0_sclk;
   logic       m1_sclk;
   logic       m0_cs_n;
   logic       m1_cs_n;
   logic [3:0] m0_io_out;
   logic [3:0] m1_io_out;
   logic [3:0] m0_io_oe;
   logic [3:0] m1_io_oe;
   logic       pad_sclk;
   logic       pad_ce0_n;
   logic       pad_ce1_n;
   logic [3:0] pad_io_out;
   logic [3:0] pad_io_oe;
   logic [3:0] pad_io_in;
   logic [3:0] io_in;
   logic       starve;
   logic       starve_clr;

   modport slave (
      input  m0_req, m1_req, m0_sclk, m1_sclk, m0_cs_n, m1_cs_n,
      input  m0_io_out, m1_io_out, m0_io_oe, m1_io_oe, pad_io_in, starve_clr,
      output m0_gnt, m1_gnt, pad_sclk, pad_ce0_n, pad_ce1_n,
      output pad_io_out, pad_io_oe, io_in, starve
   );

   modport master (
      output m0_req, m1_req, m0_sclk, m1_sclk, m0_cs_n, m1_cs_n,
      output m0_io_out, m1_io_out, m0_io_oe, m1_io_oe, pad_io_in, starve_clr,
      input  m0_gnt, m1_gnt, pad_sclk, pad_ce0_n, pad_ce1_n,
      input  pad_io_out, pad_io_oe, io_in, starve
   );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner of the shared quad-SPI pads: registered grant one edge after req, owner pins
// reach the pads combinationally, GUARD parked cycles between owners; no preemption, starvation only flagged.
module qspi_bus_arbiter #(
   parameter int GUARD    = 2,
   parameter int MAX_HOLD = 1024
) (
   input logic                clk,
   input logic                rst_n,
   qspi_bus_arbiter_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWN0  = 2'd1;
   localparam logic [1:0] ST_OWN1  = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   localparam int              HW         = $clog2(MAX_HOLD + 1);
   localparam logic [3:0]      GUARD_LOAD = 4'(GUARD - 1);
   localparam logic [HW-1:0]   HOLD_MAX   = HW'(MAX_HOLD);
   localparam logic [HW-1:0]   HOLD_LAST  = HW'(MAX_HOLD - 1);

   logic [1:0]    state, state_nxt;
   logic          last_owner, last_nxt;
   logic [3:0]    guard_cnt, guard_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          starve_q, starve_nxt;
   logic          any_req;
   logic          pick;
   logic          contended;
   logic          reach;

   assign any_req = bus.m0_req | bus.m1_req;
   // On a tie the port that did not own the bus last wins.
   assign pick = (bus.m0_req & bus.m1_req) ? ~last_owner : bus.m1_req;

   assign contended = ((state == ST_OWN0) & bus.m1_req) |
                      ((state == ST_OWN1) & bus.m0_req);
   assign reach     = contended & (hold_cnt == HOLD_LAST);

   always_comb begin
      state_nxt  = state;
      last_nxt   = last_owner;
      guard_nxt  = guard_cnt;
      hold_nxt   = hold_cnt;
      starve_nxt = reach | (starve_q & ~bus.starve_clr);

      if (contended && (hold_cnt != HOLD_MAX)) begin
         hold_nxt = hold_cnt + HW'(1);
      end

      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_nxt = pick ? ST_OWN1 : ST_OWN0;
               hold_nxt  = '0;
            end
         end
         ST_OWN0: begin
            if (!bus.m0_req) begin
               state_nxt = ST_GUARD;
               last_nxt  = 1'b0;
               guard_nxt = GUARD_LOAD;
            end
         end
         ST_OWN1: begin
            if (!bus.m1_req) begin
               state_nxt = ST_GUARD;
               last_nxt  = 1'b1;
               guard_nxt = GUARD_LOAD;
            end
         end
         default: begin
            // Last guard cycle hands over directly, without an IDLE cycle.
            if (guard_cnt == 4'd0) begin
               if (any_req) begin
                  state_nxt = pick ? ST_OWN1 : ST_OWN0;
                  hold_nxt  = '0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               guard_nxt = guard_cnt - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_owner <= 1'b1;
         guard_cnt  <= 4'd0;
         hold_cnt   <= '0;
         starve_q   <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_nxt;
         guard_cnt  <= guard_nxt;
         hold_cnt   <= hold_nxt;
         starve_q   <= starve_nxt;
      end
   end

   assign bus.m0_gnt = (state == ST_OWN0);
   assign bus.m1_gnt = (state == ST_OWN1);
   assign bus.starve = starve_q;
   assign bus.io_in  = bus.pad_io_in;

   always_comb begin
      bus.pad_sclk   = 1'b0;
      bus.pad_ce0_n  = 1'b1;
      bus.pad_ce1_n  = 1'b1;
      bus.pad_io_out = 4'h0;
      bus.pad_io_oe  = 4'h0;
      if (state == ST_OWN0) begin
         bus.pad_sclk   = bus.m0_sclk;
         bus.pad_ce0_n  = bus.m0_cs_n;
         bus.pad_io_out = bus.m0_io_out;
         bus.pad_io_oe  = bus.m0_io_oe;
      end else if (state == ST_OWN1) begin
         bus.pad_sclk   = bus.m1_sclk;
         bus.pad_ce1_n  = bus.m1_cs_n;
         bus.pad_io_out = bus.m1_io_out;
         bus.pad_io_oe  = bus.m1_io_oe;
      end
   end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against an owner/gap/hold model of the sharing rules.
module tb_qspi_bus_arbiter;
   localparam int GUARD    = 2;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   qspi_bus_arbiter_if bus ();

   qspi_bus_arbiter #(.GUARD(GUARD), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   // Model: owner -1 means nobody; gap counts parked cycles still owed after a release.
   int owner = -1;
   int gap = 0;
   int last = 1;
   int hold = 0;
   bit starve_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner = -1; gap = 0; last = 1; hold = 0; starve_m = 1'b0;
      end else begin
         bit set_s;
         bit r0, r1;
         set_s = 1'b0;
         r0 = bus.m0_req;
         r1 = bus.m1_req;
         if (owner >= 0) begin
            if (((owner == 0) ? r1 : r0) && hold < MAX_HOLD) begin
               hold++;
               if (hold == MAX_HOLD) set_s = 1'b1;
            end
            if (!((owner == 0) ? r0 : r1)) begin
               last = owner; owner = -1; gap = GUARD;
            end
         end else begin
            if (gap > 0) gap--;
            if (gap == 0 && (r0 || r1)) begin
               owner = (r0 && r1) ? (1 - last) : (r0 ? 0 : 1);
               hold = 0;
            end
         end
         starve_m = set_s ? 1'b1 : (bus.starve_clr ? 1'b0 : starve_m);
      end
   end

   function automatic logic [17:0] model_vec();
      logic sclk, c0, c1;
      logic [3:0] o, oe;
      sclk = 1'b0; c0 = 1'b1; c1 = 1'b1; o = 4'h0; oe = 4'h0;
      if (owner == 0) begin
         sclk = bus.m0_sclk; c0 = bus.m0_cs_n; o = bus.m0_io_out; oe = bus.m0_io_oe;
      end else if (owner == 1) begin
         sclk = bus.m1_sclk; c1 = bus.m1_cs_n; o = bus.m1_io_out; oe = bus.m1_io_oe;
      end
      return {owner == 0, owner == 1, sclk, c0, c1, o, oe, bus.pad_io_in, starve_m};
   endfunction

   function automatic logic [17:0] dut_vec();
      return {bus.m0_gnt, bus.m1_gnt, bus.pad_sclk, bus.pad_ce0_n, bus.pad_ce1_n,
              bus.pad_io_out, bus.pad_io_oe, bus.io_in, bus.starve};
   endfunction

   always @(negedge clk) begin
      #2;
      if (check_en) chk("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int who);
      who = -1;
      for (int i = 0; i < 20 && who < 0; i++) begin
         step(1);
         if (bus.m0_gnt) who = 0;
         else if (bus.m1_gnt) who = 1;
      end
      if (who < 0) chk("grant_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int who, prev;
      bus.m0_req = 0; bus.m1_req = 0; bus.m0_sclk = 0; bus.m1_sclk = 0;
      bus.m0_cs_n = 1; bus.m1_cs_n = 1; bus.m0_io_out = 0; bus.m1_io_out = 0;
      bus.m0_io_oe = 0; bus.m1_io_oe = 0; bus.pad_io_in = 4'hA; bus.starve_clr = 0;

      step(3);
      chk("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b00);
      chk("rst_pads", {bus.pad_sclk, bus.pad_ce0_n, bus.pad_ce1_n, bus.pad_io_out, bus.pad_io_oe},
          {1'b0, 1'b1, 1'b1, 8'h00});
      chk("rst_starve", bus.starve, 1'b0);
      chk("rst_io_in", bus.io_in, 4'hA);
      rst_n = 1'b1;
      check_en = 1'b1;
      step(1);

      // Tie right after reset goes to port 0; port 1 pins stay invisible.
      bus.m0_req = 1; bus.m1_req = 1; bus.m0_cs_n = 0; bus.m1_cs_n = 0; bus.m1_sclk = 1;
      bus.m0_io_out = 4'h5; bus.m0_io_oe = 4'hF; bus.m1_io_out = 4'h3; bus.m1_io_oe = 4'h3;
      step(1);
      chk("tie_gnt0", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
      chk("own0_ce", {bus.pad_ce0_n, bus.pad_ce1_n, bus.pad_sclk}, 3'b010);
      chk("own0_io", {bus.pad_io_out, bus.pad_io_oe}, 8'h5F);
      bus.m0_req = 0;
      step(1);
      chk("guard1", {bus.m0_gnt, bus.m1_gnt, bus.pad_ce0_n, bus.pad_ce1_n, bus.pad_io_oe}, 8'b0011_0000);
      step(1);
      chk("guard2", {bus.m0_gnt, bus.m1_gnt, bus.pad_ce0_n, bus.pad_ce1_n, bus.pad_sclk}, 5'b00110);
      chk("guard_io_in", bus.io_in, 4'hA);
      step(1);
      chk("handover_gnt1", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
      chk("own1_pads", {bus.pad_ce0_n, bus.pad_ce1_n, bus.pad_sclk, bus.pad_io_out}, 7'b1_0_1_0011);

      // Port 1 releases and re-requests at once: waiting port 0 still wins.
      bus.m0_req = 1; bus.m1_req = 0;
      step(1);
      bus.m1_req = 1;
      step(2);
      chk("rr_gnt0", {bus.m0_gnt, bus.m1_gnt}, 2'b10);

      // Starvation: set after 8th contended cycle, cleared by a pulse.
      step(7);
      chk("starve_pre", bus.starve, 1'b0);
      step(1);
      chk("starve_set", bus.starve, 1'b1);
      bus.starve_clr = 1;
      step(1);
      chk("starve_clr", bus.starve, 1'b0);
      bus.starve_clr = 0;

      // Set and clear in the same cycle: set wins.
      bus.m0_req = 0;
      step(1);
      bus.m0_req = 1;
      step(2);
      chk("rr_gnt1", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
      step(7);
      chk("starve_pre2", bus.starve, 1'b0);
      bus.starve_clr = 1;
      step(1);
      chk("starve_set_wins", bus.starve, 1'b1);
      bus.starve_clr = 0;
      step(1);
      chk("starve_sticky", bus.starve, 1'b1);

      // Asynchronous reset while port 1 owns with CE low.
      bus.m1_cs_n = 0;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {bus.m1_gnt, bus.pad_ce1_n, bus.pad_io_oe, bus.starve}, 7'b0_1_0000_0);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("post_rst_tie", {bus.m0_gnt, bus.m1_gnt}, 2'b10);

      // Ten contention rounds must alternate strictly.
      prev = -1;
      for (int r = 0; r < 10; r++) begin
         wait_gnt(who);
         if (prev >= 0) chk("alternate", who, 1 - prev);
         prev = who;
         step(2);
         if (who == 0) bus.m0_req = 0; else bus.m1_req = 0;
         step(1);
         bus.m0_req = 1; bus.m1_req = 1;
      end

      for (int c = 0; c < 4000; c++) begin
         step(1);
         if ($urandom_range(0, 7) == 0) bus.m0_req = ~bus.m0_req;
         if ($urandom_range(0, 7) == 0) bus.m1_req = ~bus.m1_req;
         bus.starve_clr = ($urandom_range(0, 15) == 0);
         bus.m0_sclk = 1'($urandom); bus.m1_sclk = 1'($urandom);
         bus.m0_cs_n = 1'($urandom); bus.m1_cs_n = 1'($urandom);
         bus.m0_io_out = 4'($urandom); bus.m1_io_out = 4'($urandom);
         bus.m0_io_oe = 4'($urandom); bus.m1_io_oe = 4'($urandom);
         bus.pad_io_in = 4'($urandom);
         rst_n = ($urandom_range(0, 999) != 0);
      end
      rst_n = 1'b1;
      step(2);
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
